// File: rtl/uart_rx_pkg.sv
// Shared definitions for the Rx frame controller: FSM state encoding and display error code.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StCommit,
    StErrHold
  } rx_state_e;

  // Byte shown on every display digit pair when a frame is aborted by a line error.
  localparam logic [7:0] ErrCode = 8'hEE;

endpackage

// File: rtl/rx_timeout_timer.sv
// Clear/enable/expire cycle counter. o_expire is high while the count sits at LIMIT-1.
// The count holds there until cleared.
module rx_timeout_timer #(
  parameter int unsigned LIMIT = 5000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int unsigned W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] Last = W'(LIMIT - 1);

  logic [W-1:0] r_cnt_q;

  // Count enabled cycles since the last clear, stopping at the terminal value.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_cnt_q <= '0;
    end else if (i_en && !o_expire) begin
      r_cnt_q <= r_cnt_q + W'(1);
    end
  end

  assign o_expire = (r_cnt_q == Last);

endmodule

// File: rtl/rx_frame_controller.sv
// Collects NUM_BYTES validated Rx bytes (MSB-first) into a display frame and commits it atomically.
// Partial frames are dropped on a line error or inter-byte timeout.
// Optional feature: define RX_FRAME_ERR_DISPLAY_EN to show "EE.." on the display on each error.
module rx_frame_controller
  import uart_rx_pkg::*;
#(
  parameter int unsigned NUM_BYTES       = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 5000,
  parameter int unsigned ERR_HOLD_CYCLES = 16,
  parameter int unsigned CNT_W           = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             Rx_DATA,
  input  logic                   Rx_VALID,
  input  logic                   Rx_FERROR,
  input  logic                   Rx_PERROR,
  output logic [8*NUM_BYTES-1:0] msg_digits,
  output logic                   msg_update,
  output logic                   busy,
  output logic [CNT_W-1:0]       frame_count,
  output logic [CNT_W-1:0]       err_count,
  output logic                   timeout
);

  localparam int unsigned IdxW = $clog2(NUM_BYTES + 1);

  rx_state_e              r_state_q, r_state_d;
  logic [7:0]             r_buf_q [NUM_BYTES];
  logic [7:0]             r_buf_d [NUM_BYTES];
  logic [IdxW-1:0]        r_idx_q, r_idx_d;
  logic [8*NUM_BYTES-1:0] r_msg_q, r_msg_d;
  logic                   r_upd_q, r_upd_d;
  logic                   r_to_q, r_to_d;
  logic [CNT_W-1:0]       r_fc_q, r_fc_d;
  logic [CNT_W-1:0]       r_ec_q, r_ec_d;
  logic                   r_valid_q, r_err_q;

  logic                   w_err_lvl, w_accept, w_err_evt;
  logic [IdxW-1:0]        w_wr_idx;
  logic                   w_last, w_take, w_abort;
  logic                   w_byte_expire, w_hold_expire;
  logic [CNT_W-1:0]       w_ec_inc;

  assign w_err_lvl = Rx_FERROR | Rx_PERROR;
  // A byte counts only on the rising edge of VALID on a clean line.
  assign w_accept  = Rx_VALID & ~r_valid_q & ~w_err_lvl;
  assign w_err_evt = w_err_lvl & ~r_err_q;
  // Outside COLLECT an accepted byte always starts a new frame at slot 0.
  assign w_wr_idx  = (r_state_q == StCollect) ? r_idx_q : '0;
  assign w_last    = (w_wr_idx == IdxW'(NUM_BYTES - 1));
  assign w_ec_inc  = (r_ec_q == '1) ? r_ec_q : r_ec_q + CNT_W'(1);

  rx_timeout_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_byte_timer (
    .i_clk    (clk),
    .i_rst_n  (reset),
    .i_clr    ((r_state_q != StCollect) || w_accept),
    .i_en     (r_state_q == StCollect),
    .o_expire (w_byte_expire)
  );

  rx_timeout_timer #(
    .LIMIT (ERR_HOLD_CYCLES)
  ) u_hold_timer (
    .i_clk    (clk),
    .i_rst_n  (reset),
    .i_clr    (r_state_q != StErrHold),
    .i_en     (r_state_q == StErrHold),
    .o_expire (w_hold_expire)
  );

  // Next-state, buffer, display and counter updates.
  always_comb begin
    r_state_d = r_state_q;
    r_buf_d   = r_buf_q;
    r_idx_d   = r_idx_q;
    r_msg_d   = r_msg_q;
    r_upd_d   = 1'b0;
    r_to_d    = 1'b0;
    r_fc_d    = r_fc_q;
    r_ec_d    = r_ec_q;
    w_take    = 1'b0;
    w_abort   = 1'b0;

    unique case (r_state_q)
      StIdle, StCommit: begin
        if (w_err_evt) begin
          w_abort = 1'b1;
        end else if (w_accept) begin
          w_take = 1'b1;
        end else begin
          r_state_d = StIdle;
        end
      end
      StCollect: begin
        if (w_err_evt) begin
          w_abort = 1'b1;
        end else if (w_accept) begin
          w_take = 1'b1;
        end else if (w_byte_expire) begin
          r_state_d = StIdle;
          r_to_d    = 1'b1;
          r_ec_d    = w_ec_inc;
          r_idx_d   = '0;
          for (int i = 0; i < NUM_BYTES; i++) r_buf_d[i] = '0;
        end
      end
      StErrHold: begin
        if (w_hold_expire) r_state_d = StIdle;
      end
    endcase

    if (w_take) begin
      r_buf_d[w_wr_idx] = Rx_DATA;
      if (w_last) begin
        // Load the display on entry to COMMIT so digits and the update pulse line up.
        r_state_d = StCommit;
        r_idx_d   = '0;
        r_upd_d   = 1'b1;
        r_fc_d    = r_fc_q + CNT_W'(1);
        for (int i = 0; i < NUM_BYTES; i++) r_msg_d[8*(NUM_BYTES-1-i) +: 8] = r_buf_d[i];
      end else begin
        r_state_d = StCollect;
        r_idx_d   = w_wr_idx + IdxW'(1);
      end
    end

    if (w_abort) begin
      r_state_d = StErrHold;
      r_ec_d    = w_ec_inc;
      r_idx_d   = '0;
      for (int i = 0; i < NUM_BYTES; i++) r_buf_d[i] = '0;
`ifdef RX_FRAME_ERR_DISPLAY_EN
      r_msg_d   = {NUM_BYTES{ErrCode}};
      r_upd_d   = 1'b1;
`endif
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state_q <= StIdle;
      for (int i = 0; i < NUM_BYTES; i++) r_buf_q[i] <= '0;
      r_idx_q   <= '0;
      r_msg_q   <= '0;
      r_upd_q   <= 1'b0;
      r_to_q    <= 1'b0;
      r_fc_q    <= '0;
      r_ec_q    <= '0;
      r_valid_q <= 1'b0;
      r_err_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_buf_q   <= r_buf_d;
      r_idx_q   <= r_idx_d;
      r_msg_q   <= r_msg_d;
      r_upd_q   <= r_upd_d;
      r_to_q    <= r_to_d;
      r_fc_q    <= r_fc_d;
      r_ec_q    <= r_ec_d;
      r_valid_q <= Rx_VALID;
      r_err_q   <= w_err_lvl;
    end
  end

  assign msg_digits  = r_msg_q;
  assign msg_update  = r_upd_q;
  assign busy        = (r_state_q != StIdle);
  assign frame_count = r_fc_q;
  assign err_count   = r_ec_q;
  assign timeout     = r_to_q;

endmodule

// File: tb/tb_rx_frame_controller.sv
// Self-checking bench for rx_frame_controller: a queue-based frame model checked every cycle,
// plus literal expectations for each directed scenario.
module tb_rx_frame_controller;

  localparam int NB = 2;
  localparam int TO = 5000;
  localparam int EH = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [7:0]      Rx_DATA = 8'h00;
  logic            Rx_VALID = 1'b0;
  logic            Rx_FERROR = 1'b0;
  logic            Rx_PERROR = 1'b0;
  logic [8*NB-1:0] msg_digits;
  logic            msg_update, busy, timeout;
  logic [7:0]      frame_count, err_count;

  rx_frame_controller #(
    .NUM_BYTES       (NB),
    .TIMEOUT_CYCLES  (TO),
    .ERR_HOLD_CYCLES (EH),
    .CNT_W           (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .Rx_DATA     (Rx_DATA),
    .Rx_VALID    (Rx_VALID),
    .Rx_FERROR   (Rx_FERROR),
    .Rx_PERROR   (Rx_PERROR),
    .msg_digits  (msg_digits),
    .msg_update  (msg_update),
    .busy        (busy),
    .frame_count (frame_count),
    .err_count   (err_count),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

`ifdef RX_FRAME_ERR_DISPLAY_EN
  localparam logic [31:0] ErrDigits = 32'hEEEE;
  localparam int ErrUpd = 1;
`else
  localparam logic [31:0] ErrDigits = 32'h0;
  localparam int ErrUpd = 0;
`endif

  // ---------------- behavioural model ----------------
  logic [7:0]      m_q[$];
  int              m_hold = 0;
  int              m_gap = 0;
  logic [8*NB-1:0] m_digits = '0;
  logic [7:0]      m_fc = '0, m_ec = '0;
  logic            m_upd = 0, m_to = 0, m_commit = 0;
  logic            m_pv = 0, m_pe = 0;
  logic            m_ready = 0;

  always @(posedge clk) begin
    logic acc, errv;
    acc = Rx_VALID && !m_pv && !Rx_FERROR && !Rx_PERROR;
    errv = (Rx_FERROR || Rx_PERROR) && !m_pe;
    m_upd = 0;
    m_to = 0;
    m_commit = 0;
    if (!reset) begin
      m_q.delete();
      m_hold = 0;
      m_gap = 0;
      m_digits = '0;
      m_fc = '0;
      m_ec = '0;
      m_pv = 0;
      m_pe = 0;
      m_ready = 1;
    end else begin
      if (m_hold > 0) begin
        m_hold--;
      end else if (errv) begin
        if (m_ec != 8'hFF) m_ec++;
        m_q.delete();
        m_hold = EH;
`ifdef RX_FRAME_ERR_DISPLAY_EN
        m_digits = {NB{8'hEE}};
        m_upd = 1;
`endif
      end else if (acc) begin
        m_q.push_back(Rx_DATA);
        m_gap = 0;
        if (m_q.size() == NB) begin
          m_digits = '0;
          foreach (m_q[i]) m_digits = (m_digits << 8) | (8*NB)'(m_q[i]);
          m_upd = 1;
          m_commit = 1;
          m_fc++;
          m_q.delete();
        end
      end else if (m_q.size() > 0) begin
        if (m_gap == TO - 1) begin
          m_to = 1;
          if (m_ec != 8'hFF) m_ec++;
          m_q.delete();
        end else begin
          m_gap++;
        end
      end
      m_pv = Rx_VALID;
      m_pe = Rx_FERROR || Rx_PERROR;
    end
  end

  // ---------------- literal expectation queue ----------------
  typedef struct {
    string       name;
    int          sig;
    logic [31:0] exp;
  } lit_t;
  lit_t lit_q[$];

  // ---------------- compare process ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int upd_seen = 0;
  int to_seen = 0;
  int lit_rd = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] act;
    if (m_ready) begin
      chk("msg_digits", 32'(msg_digits), 32'(m_digits));
      chk("msg_update", 32'(msg_update), 32'(m_upd));
      chk("busy", 32'(busy), 32'(m_hold > 0 || m_q.size() > 0 || m_commit));
      chk("frame_count", 32'(frame_count), 32'(m_fc));
      chk("err_count", 32'(err_count), 32'(m_ec));
      chk("timeout", 32'(timeout), 32'(m_to));
      if (msg_update === 1'b1) upd_seen++;
      if (timeout === 1'b1) to_seen++;
    end
    while (lit_rd < lit_q.size()) begin
      case (lit_q[lit_rd].sig)
        0: act = 32'(msg_digits);
        1: act = 32'(frame_count);
        2: act = 32'(err_count);
        3: act = 32'(busy);
        4: act = 32'(upd_seen);
        default: act = 32'(to_seen);
      endcase
      chk(lit_q[lit_rd].name, act, lit_q[lit_rd].exp);
      lit_rd++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic lit(input string nm, input int sig, input logic [31:0] exp);
    lit_q.push_back('{nm, sig, exp});
  endtask

  task automatic do_reset();
    reset = 1'b0;
    Rx_VALID = 1'b0;
    Rx_FERROR = 1'b0;
    Rx_PERROR = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
  endtask

  task automatic send(input logic [7:0] d, input int hi, input int gap);
    Rx_DATA = d;
    Rx_VALID = 1'b1;
    tick(hi);
    Rx_VALID = 1'b0;
    tick(gap);
  endtask

  initial begin
    int base_u, base_t;
    #1;
    // 1) Reset state, then a two-byte frame with multi-cycle VALID.
    tick(2);
    lit("reset_digits", 0, 32'h0);
    lit("reset_fc", 1, 32'h0);
    lit("reset_busy", 3, 32'h0);
    reset = 1'b1;
    tick(1);
    base_u = upd_seen;
    send(8'h12, 2, 2);
    send(8'h34, 2, 3);
    lit("t1_digits", 0, 32'h1234);
    lit("t1_fc", 1, 32'd1);
    lit("t1_updates", 4, 32'(base_u + 1));

    // 2) Parity error mid-frame, byte during hold ignored, then a good frame.
    do_reset();
    send(8'hAB, 1, 2);
    base_u = upd_seen;
    Rx_PERROR = 1'b1;
    tick(2);
    Rx_PERROR = 1'b0;
    lit("t2_err_digits", 0, ErrDigits);
    lit("t2_err_busy", 3, 32'd1);
    lit("t2_err_ec", 2, 32'd1);
    tick(2);
    send(8'hCC, 1, 20);
    lit("t2_hold_updates", 4, 32'(base_u + ErrUpd));
    send(8'h56, 1, 1);
    send(8'h78, 1, 3);
    lit("t2_digits", 0, 32'h5678);
    lit("t2_fc", 1, 32'd1);
    lit("t2_ec", 2, 32'd1);

    // 3) Good frame, then a lone byte that times out.
    do_reset();
    send(8'hC3, 1, 1);
    send(8'h5A, 1, 3);
    base_t = to_seen;
    send(8'h9A, 1, 0);
    tick(TO + 5);
    lit("t3_timeouts", 5, 32'(base_t + 1));
    lit("t3_ec", 2, 32'd1);
    lit("t3_digits", 0, 32'hC35A);
    lit("t3_busy", 3, 32'd0);

    // 4) VALID and FERROR rise together: error wins, byte dropped.
    do_reset();
    Rx_DATA = 8'h77;
    Rx_VALID = 1'b1;
    Rx_FERROR = 1'b1;
    tick(2);
    lit("t4_busy", 3, 32'd1);
    lit("t4_ec", 2, 32'd1);
    Rx_VALID = 1'b0;
    Rx_FERROR = 1'b0;
    tick(20);
    lit("t4_fc", 1, 32'd0);
    lit("t4_digits", 0, ErrDigits);

    // 5) frame_count wrap after 256 frames; err_count saturation after 300 errors.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      send(8'(i), 1, 1);
      send(8'(i) ^ 8'hFF, 1, 1);
    end
    tick(2);
    lit("t5_fc_wrap", 1, 32'd0);
    lit("t5_digits", 0, 32'hFF00);
    for (int i = 0; i < 300; i++) begin
      Rx_FERROR = 1'b1;
      tick(1);
      Rx_FERROR = 1'b0;
      tick(17);
    end
    lit("t5_ec_sat", 2, 32'hFF);

    // 6) Reset mid-frame clears everything, then a fresh frame.
    do_reset();
    send(8'hAA, 1, 1);
    send(8'hBB, 1, 2);
    send(8'h11, 1, 1);
    reset = 1'b0;
    tick(2);
    lit("t6_rst_digits", 0, 32'h0);
    lit("t6_rst_fc", 1, 32'd0);
    lit("t6_rst_busy", 3, 32'd0);
    reset = 1'b1;
    tick(1);
    send(8'h22, 1, 1);
    send(8'h33, 1, 3);
    lit("t6_digits", 0, 32'h2233);
    lit("t6_fc", 1, 32'd1);

    tick(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
